// File: rtl/pe_pkg.sv
// pe_pkg: shared geometry and FSM state for the MAC4 processing element and its front end.
package pe_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int NUM_MAC4 = 16;
  localparam int WORD_WIDTH = 4 * DATA_WIDTH;
  localparam int TOTAL_INPUT_WIDTH = NUM_MAC4 * WORD_WIDTH;
  localparam int BEATS = TOTAL_INPUT_WIDTH / WORD_WIDTH;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/pe_beat_packer.sv
// pe_beat_packer: packs one valid/ready beat stream into a full operand vector with a side value.
module pe_beat_packer #(
  parameter int WORD_WIDTH = 32,
  parameter int BEATS = 16,
  parameter int SIDE_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        clr,
  input  logic [WORD_WIDTH-1:0]       word,
  input  logic                        valid,
  output logic                        ready,
  input  logic [SIDE_WIDTH-1:0]       side_in,
  output logic [BEATS*WORD_WIDTH-1:0] vec,
  output logic [SIDE_WIDTH-1:0]       side_q,
  output logic                        full
);
  localparam int CW = $clog2(BEATS);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
  logic [CW-1:0] cnt;
  assign ready = en && !full;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      full <= 1'b0;
      vec <= '0;
      side_q <= '0;
    end else if (valid && ready) begin
      vec[cnt*WORD_WIDTH +: WORD_WIDTH] <= word;
      cnt <= cnt == LAST ? '0 : cnt + 1'b1;
      full <= cnt == LAST;
      if (cnt == LAST) side_q <= side_in;
    end else if (clr) begin
      full <= 1'b0;
    end
  end
endmodule

// File: rtl/pe_operand_packer.sv
// pe_operand_packer: packs activation and weight beat streams into PE operand vectors, counted per job.
module pe_operand_packer #(
  parameter int DATA_WIDTH = pe_pkg::DATA_WIDTH,
  parameter int NUM_MAC4 = pe_pkg::NUM_MAC4,
  parameter int WORD_WIDTH = 4 * DATA_WIDTH,
  parameter int TOTAL_INPUT_WIDTH = NUM_MAC4 * 4 * DATA_WIDTH,
  parameter int BEATS = TOTAL_INPUT_WIDTH / WORD_WIDTH,
  parameter int CNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [CNT_WIDTH-1:0]         cfg_num_vec,
  input  logic [WORD_WIDTH-1:0]        in_data_word,
  input  logic                         in_data_valid,
  output logic                         in_data_ready,
  input  logic [WORD_WIDTH-1:0]        in_wt_word,
  input  logic                         in_wt_valid,
  output logic                         in_wt_ready,
  input  logic signed [DATA_WIDTH-1:0] in_bias,
  output logic [TOTAL_INPUT_WIDTH-1:0] out_data,
  output logic [TOTAL_INPUT_WIDTH-1:0] out_weights,
  output logic signed [DATA_WIDTH-1:0] out_bias,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy,
  output logic                         done
);
  import pe_pkg::*;
  state_t state, state_nxt;
  logic [CNT_WIDTH-1:0] num_vec, issued;
  logic [1:0] valid, ready, full;
  logic [WORD_WIDTH-1:0] word [2];
  logic [DATA_WIDTH-1:0] side_in [2];
  logic [DATA_WIDTH-1:0] side [2];
  logic [TOTAL_INPUT_WIDTH-1:0] vec [2];
  logic en, xfer;
  assign en = state == RUN && issued < num_vec;
  assign xfer = &full && (!out_valid || out_ready);
  assign word[0] = in_data_word;
  assign word[1] = in_wt_word;
  assign side_in[0] = '0;
  assign side_in[1] = in_bias;
  assign valid = {in_wt_valid, in_data_valid};
  assign in_data_ready = ready[0];
  assign in_wt_ready = ready[1];
  assign busy = state == RUN || state == DRAIN;
  assign done = state == DONE;
  for (genvar g = 0; g < 2; g++) begin : g_pack
    pe_beat_packer #(
      .WORD_WIDTH(WORD_WIDTH),
      .BEATS(BEATS),
      .SIDE_WIDTH(DATA_WIDTH)
    ) u_pack (
      .clk(clk),
      .rst(rst),
      .en(en),
      .clr(xfer),
      .word(word[g]),
      .valid(valid[g]),
      .ready(ready[g]),
      .side_in(side_in[g]),
      .vec(vec[g]),
      .side_q(side[g]),
      .full(full[g])
    );
  end
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: state_nxt = !start ? IDLE : cfg_num_vec == '0 ? DONE : RUN;
      RUN: state_nxt = issued == num_vec ? DRAIN : RUN;
      DRAIN: state_nxt = !out_valid || out_ready ? DONE : DRAIN;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      num_vec <= '0;
      issued <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_weights <= '0;
      out_bias <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        num_vec <= cfg_num_vec;
        issued <= '0;
      end else if (xfer) begin
        issued <= issued + 1'b1;
      end
      if (xfer) begin
        out_data <= vec[0];
        out_weights <= vec[1];
        out_bias <= side[1];
      end
      out_valid <= xfer || (out_valid && !out_ready);
    end
  end
endmodule

// File: tb/tb_pe_operand_packer.sv
// tb_pe_operand_packer: directed scoreboard bench for pe_operand_packer.
module tb_pe_operand_packer;
  localparam int W = 32;
  localparam int B = 16;
  localparam int TW = 512;
  localparam int DW = 8;
  localparam int CW = 16;
  typedef struct packed {
    logic [TW-1:0] d;
    logic [TW-1:0] w;
    logic [DW-1:0] b;
  } vec_t;
  logic clk = 1'b0;
  logic rst, start, in_data_valid, in_wt_valid, out_ready;
  logic [CW-1:0] cfg_num_vec;
  logic [W-1:0] in_data_word, in_wt_word;
  logic in_data_ready, in_wt_ready, out_valid, busy, done;
  logic signed [DW-1:0] in_bias, out_bias;
  logic [TW-1:0] out_data, out_weights;
  logic [W-1:0] dbeat [B];
  logic [W-1:0] wbeat [B];
  vec_t exp_q[$], obs_q[$];
  int checks = 0, errors = 0;
  int done_cnt = 0, rdy_seen = 0, ov_seen = 0;
  always #5 clk = ~clk;
  pe_operand_packer dut (
    .clk(clk), .rst(rst), .start(start), .cfg_num_vec(cfg_num_vec),
    .in_data_word(in_data_word), .in_data_valid(in_data_valid), .in_data_ready(in_data_ready),
    .in_wt_word(in_wt_word), .in_wt_valid(in_wt_valid), .in_wt_ready(in_wt_ready),
    .in_bias(in_bias), .out_data(out_data), .out_weights(out_weights), .out_bias(out_bias),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) obs_q.push_back('{out_data, out_weights, out_bias});
    if (done) done_cnt++;
    if (in_data_ready || in_wt_ready) rdy_seen++;
    if (out_valid) ov_seen++;
  end
  task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic vec_t mk(input logic [DW-1:0] bias);
    vec_t v;
    for (int k = 0; k < B; k++) begin
      v.d[k*W +: W] = dbeat[k];
      v.w[k*W +: W] = wbeat[k];
    end
    v.b = bias;
    return v;
  endfunction
  task automatic randomize_beats();
    for (int k = 0; k < B; k++) begin
      dbeat[k] = $urandom;
      wbeat[k] = $urandom;
    end
  endtask
  task automatic start_job(input int n);
    start = 1'b1;
    cfg_num_vec = CW'(n);
    tick();
    start = 1'b0;
  endtask
  task automatic send(input int nd, input int nw, input logic [DW-1:0] bias);
    int di, wi, n;
    logic da, wa;
    di = 0;
    wi = 0;
    n = 0;
    while ((di < nd || wi < nw) && n < 400) begin
      in_data_valid = di < nd;
      in_data_word = di < nd ? dbeat[di] : '0;
      in_wt_valid = wi < nw;
      in_wt_word = wi < nw ? wbeat[wi] : '0;
      in_bias = bias;
      da = in_data_valid && in_data_ready;
      wa = in_wt_valid && in_wt_ready;
      tick();
      if (da) di++;
      if (wa) wi++;
      n++;
    end
    in_data_valid = 1'b0;
    in_wt_valid = 1'b0;
    chk("send_complete", TW'(di >= nd && wi >= nw), TW'(1));
  endtask
  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    chk("done_seen", TW'(done), TW'(1));
    tick();
  endtask
  task automatic drain_check(input string tag);
    vec_t o, e;
    chk({tag, "_count"}, TW'(obs_q.size()), TW'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_data"}, o.d, e.d);
      chk({tag, "_weights"}, o.w, e.w);
      chk({tag, "_bias"}, TW'(o.b), TW'(e.b));
    end
    obs_q.delete();
    exp_q.delete();
  endtask
  initial begin
    logic [TW-1:0] lb;
    logic [DW-1:0] bias;
    int r0, v0, d0;
    rst = 1'b1;
    start = 1'b0;
    cfg_num_vec = '0;
    in_data_valid = 1'b0;
    in_wt_valid = 1'b0;
    in_data_word = '0;
    in_wt_word = '0;
    in_bias = '0;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_out_valid", TW'(out_valid), TW'(0));
    chk("rst_readies", TW'({in_data_ready, in_wt_ready}), TW'(0));
    chk("rst_busy_done", TW'({busy, done}), TW'(0));
    chk("rst_out_data", out_data, '0);
    chk("rst_out_weights", out_weights, '0);
    chk("rst_out_bias", TW'({out_bias}), TW'(0));
    rst = 1'b0;
    tick();
    // basic vector: activation bytes count 0..63, weights all ones
    for (int k = 0; k < B; k++) begin
      dbeat[k] = 32'h03020100 + k * 32'h04040404;
      wbeat[k] = 32'h01010101;
    end
    start_job(1);
    chk("ready_after_start", TW'({in_data_ready, in_wt_ready, busy}), TW'(3'b111));
    exp_q.push_back(mk(8'hFB));
    send(B, B, 8'hFB);
    chk("basic_valid_before", TW'(out_valid), TW'(0));
    tick();
    chk("basic_valid_rise", TW'(out_valid), TW'(1));
    for (int j = 0; j < 64; j++) lb[j*8 +: 8] = 8'(j);
    chk("basic_bytes", out_data, lb);
    chk("basic_weights", out_weights, {64{8'h01}});
    chk("basic_bias", TW'({out_bias}), TW'(8'hFB));
    tick();
    chk("basic_valid_one_cycle", TW'(out_valid), TW'(0));
    wait_done();
    drain_check("basic_sb");
    // skewed: weights complete long before data
    randomize_beats();
    bias = 8'($urandom);
    start_job(1);
    exp_q.push_back(mk(bias));
    send(0, B, bias);
    chk("skew_wt_ready_low", TW'(in_wt_ready), TW'(0));
    repeat (10) tick();
    chk("skew_hold", TW'({in_wt_ready, in_data_ready, out_valid}), TW'(3'b010));
    send(B, 0, 8'h00);
    chk("skew_valid_before", TW'(out_valid), TW'(0));
    tick();
    chk("skew_valid_rise", TW'(out_valid), TW'(1));
    wait_done();
    drain_check("skew_sb");
    // backpressure: three vectors with the output stalled
    start_job(3);
    out_ready = 1'b0;
    randomize_beats();
    bias = 8'($urandom);
    exp_q.push_back(mk(bias));
    send(B, B, bias);
    randomize_beats();
    bias = 8'($urandom);
    exp_q.push_back(mk(bias));
    send(B, B, bias);
    repeat (3) tick();
    chk("bp_readies_low", TW'({in_data_ready, in_wt_ready}), TW'(0));
    chk("bp_valid_held", TW'(out_valid), TW'(1));
    chk("bp_v0_stable", out_data, exp_q[0].d);
    repeat (20) tick();
    chk("bp_v0_still", out_weights, exp_q[0].w);
    out_ready = 1'b1;
    randomize_beats();
    bias = 8'($urandom);
    exp_q.push_back(mk(bias));
    send(B, B, bias);
    wait_done();
    drain_check("bp_sb");
    // zero-length job
    r0 = rdy_seen;
    v0 = ov_seen;
    d0 = done_cnt;
    start_job(0);
    wait_done();
    chk("zero_ready_never", TW'(rdy_seen - r0), TW'(0));
    chk("zero_valid_never", TW'(ov_seen - v0), TW'(0));
    chk("zero_one_done", TW'(done_cnt - d0), TW'(1));
    // reset after a partial activation fill
    start_job(1);
    randomize_beats();
    send(7, 0, 8'h00);
    rst = 1'b1;
    tick();
    chk("midrst_out_data", out_data, '0);
    chk("midrst_out_weights", out_weights, '0);
    chk("midrst_ctrl", TW'({out_valid, in_data_ready, in_wt_ready, busy, done, out_bias}), TW'(0));
    rst = 1'b0;
    tick();
    obs_q.delete();
    randomize_beats();
    bias = 8'($urandom);
    start_job(1);
    exp_q.push_back(mk(bias));
    send(B, B, bias);
    wait_done();
    drain_check("midrst_sb");
    // start pulsed while running must not reload the count
    d0 = done_cnt;
    start_job(2);
    randomize_beats();
    bias = 8'($urandom);
    exp_q.push_back(mk(bias));
    send(B, B, bias);
    start = 1'b1;
    cfg_num_vec = CW'(9);
    tick();
    start = 1'b0;
    randomize_beats();
    bias = 8'($urandom);
    exp_q.push_back(mk(bias));
    send(B, B, bias);
    wait_done();
    repeat (5) tick();
    chk("busy_start_one_done", TW'(done_cnt - d0), TW'(1));
    chk("busy_start_idle", TW'({busy, in_data_ready}), TW'(0));
    drain_check("busy_sb");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
